// File: rtl/seq_alu_pkg.sv
// -----------------------------------------------------------------------------
// seq_alu_pkg
// Shared constants for the sequential ALU: the ALU2OP_* 5-bit operation
// codes, the control FSM state type, the per-op flag update mask and the
// signed-overflow helpers used by the add/subtract paths.
// -----------------------------------------------------------------------------
package seq_alu_pkg;

  localparam logic [4:0] ALU2OP_PD1 = 5'd0;
  localparam logic [4:0] ALU2OP_PD2 = 5'd1;
  localparam logic [4:0] ALU2OP_ADD = 5'd2;
  localparam logic [4:0] ALU2OP_SUB = 5'd3;
  localparam logic [4:0] ALU2OP_ADC = 5'd4;
  localparam logic [4:0] ALU2OP_SBB = 5'd5;
  localparam logic [4:0] ALU2OP_SAR = 5'd6;
  localparam logic [4:0] ALU2OP_SLR = 5'd7;
  localparam logic [4:0] ALU2OP_SAL = 5'd8;
  localparam logic [4:0] ALU2OP_SLL = 5'd9;
  localparam logic [4:0] ALU2OP_ROL = 5'd10;
  localparam logic [4:0] ALU2OP_ROR = 5'd11;
  localparam logic [4:0] ALU2OP_AND = 5'd12;
  localparam logic [4:0] ALU2OP_OR  = 5'd13;
  localparam logic [4:0] ALU2OP_XOR = 5'd14;
  localparam logic [4:0] ALU2OP_NOT = 5'd15;
  localparam logic [4:0] ALU2OP_MUL = 5'd16;
  localparam logic [4:0] ALU2OP_DIV = 5'd17;

  typedef enum logic {ST_IDLE, ST_BUSY} state_e;

  // Which architectural registers a single-cycle op writes.
  typedef struct packed {
    logic res;  // o_Result (and clears o_ResultHi)
    logic zs;   // Z and S
    logic c;    // carry/borrow
    logic of;   // signed overflow
  } upd_t;

  function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb == b_msb) && (r_msb != a_msb);
  endfunction

  function automatic logic sub_ovf(input logic a_msb, input logic b_msb, input logic r_msb);
    return (a_msb != b_msb) && (r_msb != a_msb);
  endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// -----------------------------------------------------------------------------
// seq_alu_muldiv
// WIDTH-step iterative unsigned multiply (shift-add) and restoring divide.
// Operands load on start; one step runs per clock while active; done is high
// during the cycle whose closing edge performs the final step, so res_lo /
// res_hi carry the finished result exactly when done is high.
//   clk, rst         clock, synchronous active-high reset
//   start, is_div    load operands and select divide (1) or multiply (0)
//   op_a, op_b       multiplicand/multiplier or dividend/divisor
//   done             final-step strobe
//   div_mode         operation captured at start
//   res_lo, res_hi   step result: product low/high or quotient/remainder
// -----------------------------------------------------------------------------
module seq_alu_muldiv #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             is_div,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             done,
  output logic             div_mode,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  logic             active;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] hi, lo, m;
  logic [WIDTH:0]   mul_sum, div_shift, div_diff;
  logic             div_ge;

  // Multiply: {hi,lo} starts as {0,op_a}; each step conditionally adds the
  // multiplicand into hi and shifts the pair right, carry entering hi MSB.
  // Divide: {hi,lo} starts as {0,dividend}; each step shifts one dividend bit
  // into the partial remainder and keeps the subtraction if it did not borrow.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[WIDTH-1]};
    div_diff  = div_shift - {1'b0, m};
    div_ge    = ~div_diff[WIDTH];
    if (div_mode) begin
      res_hi = div_ge ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];
      res_lo = {lo[WIDTH-2:0], div_ge};
    end else begin
      res_hi = mul_sum[WIDTH:1];
      res_lo = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  assign done = active && (cnt == '0);

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (rst) begin
      active <= 1'b0;
      cnt    <= '0;
    end else if (start) begin
      active <= 1'b1;
      cnt    <= LAST_STEP;
    end else if (active) begin
      cnt <= cnt - CW'(1);
      if (cnt == '0) active <= 1'b0;
    end
  end

  // NOTE: datapath registers are deliberately left out of reset; they are
  // always loaded on start before being observed, which keeps reset fan-out
  // to the control flops only.
  always_ff @(posedge clk) begin
    if (start) begin
      hi       <= '0;
      lo       <= op_a;
      m        <= op_b;
      div_mode <= is_div;
    end else if (active) begin
      hi <= res_hi;
      lo <= res_lo;
    end
  end

endmodule

// File: rtl/seq_alu.sv
// -----------------------------------------------------------------------------
// seq_alu
// Multi-cycle ALU with valid/ready issue, carry chaining (ADC/SBB), shifts,
// rotates, logic ops and iterative unsigned MUL/DIV with a double-width result.
//   i_CLK, i_RST              clock, synchronous active-high reset
//   i_Valid / o_Ready         request handshake (accept on i_Valid && o_Ready)
//   i_ALUOp                   ALU2OP_* code
//   i_Data1, i_Data2          operands
//   o_Valid                   one-cycle result strobe
//   o_Result, o_ResultHi      result / MUL high half or DIV remainder
//   o_Z, o_S, o_C, o_OF       flag register
//   o_DivZero                 pulses with o_Valid for a divide by zero
// -----------------------------------------------------------------------------
module seq_alu
  import seq_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_Valid,
  output logic             o_Ready,
  input  logic [4:0]       i_ALUOp,
  input  logic [WIDTH-1:0] i_Data1,
  input  logic [WIDTH-1:0] i_Data2,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Result,
  output logic [WIDTH-1:0] o_ResultHi,
  output logic             o_Z,
  output logic             o_S,
  output logic             o_C,
  output logic             o_OF,
  output logic             o_DivZero
);

  localparam int SW = $clog2(WIDTH);
  localparam logic [WIDTH-1:0] W_VAL = WIDTH'(WIDTH);

  state_e           state;
  logic             div_zero, md_start, md_done, md_div, carry_in, is_shift;
  logic [WIDTH-1:0] md_lo, md_hi, alu_res, rot_amt, rol_res, ror_res;
  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w, sar_w;
  logic [SW-1:0]    sh_amt;
  logic             sh_big, sh_zero, rot_zero, alu_c, alu_of;
  upd_t             upd;

  assign div_zero = (i_ALUOp == ALU2OP_DIV) && (i_Data2 == '0);
  assign md_start = (state == ST_IDLE) && i_Valid &&
                    ((i_ALUOp == ALU2OP_MUL) || ((i_ALUOp == ALU2OP_DIV) && !div_zero));
  assign carry_in = ((i_ALUOp == ALU2OP_ADC) || (i_ALUOp == ALU2OP_SBB)) && o_C;
  assign is_shift = (i_ALUOp >= ALU2OP_SAR) && (i_ALUOp <= ALU2OP_ROR);

  // Shift amounts below WIDTH fit in sh_amt exactly; sh_big covers the rest.
  // The extra bit on each shift vector catches the last bit shifted out.
  assign sh_amt   = i_Data2[SW-1:0];
  assign sh_big   = (i_Data2 >= W_VAL);
  assign sh_zero  = (i_Data2 == '0);
  assign rot_amt  = i_Data2 % W_VAL;
  assign rot_zero = (rot_amt == '0);
  assign add_w    = {1'b0, i_Data1} + {1'b0, i_Data2} + (WIDTH+1)'(carry_in);
  assign sub_w    = {1'b0, i_Data1} - {1'b0, i_Data2} - (WIDTH+1)'(carry_in);
  assign shl_w    = {1'b0, i_Data1} << sh_amt;
  assign shr_w    = {i_Data1, 1'b0} >> sh_amt;
  assign sar_w    = $signed({i_Data1, 1'b0}) >>> sh_amt;
  assign rol_res  = (i_Data1 << rot_amt) | (i_Data1 >> (W_VAL - rot_amt));
  assign ror_res  = (i_Data1 >> rot_amt) | (i_Data1 << (W_VAL - rot_amt));

  // NOTE: every output of this block gets a default first, so no path through
  // the case statement leaves a value unassigned and no latch is inferred.
  always_comb begin
    alu_res = i_Data1;
    alu_c   = o_C;
    alu_of  = o_OF;
    upd     = '0;
    unique case (i_ALUOp)
      ALU2OP_PD1: upd.res = 1'b1;
      ALU2OP_PD2: begin alu_res = i_Data2; upd.res = 1'b1; end
      ALU2OP_NOT: begin alu_res = ~i_Data1; upd.res = 1'b1; end
      ALU2OP_ADD, ALU2OP_ADC: begin
        alu_res = add_w[WIDTH-1:0];
        alu_c   = add_w[WIDTH];
        alu_of  = add_ovf(i_Data1[WIDTH-1], i_Data2[WIDTH-1], alu_res[WIDTH-1]);
        upd     = '1;
      end
      ALU2OP_SUB, ALU2OP_SBB: begin
        alu_res = sub_w[WIDTH-1:0];
        alu_c   = sub_w[WIDTH];
        alu_of  = sub_ovf(i_Data1[WIDTH-1], i_Data2[WIDTH-1], alu_res[WIDTH-1]);
        upd     = '1;
      end
      ALU2OP_SAR: begin
        if (sh_big) begin
          alu_res = {WIDTH{i_Data1[WIDTH-1]}};
          alu_c   = i_Data1[WIDTH-1];
        end else if (!sh_zero) begin
          alu_res = sar_w[WIDTH:1];
          alu_c   = sar_w[0];
        end
        upd = '{res: 1'b1, zs: 1'b1, c: !sh_zero, of: 1'b1};
      end
      ALU2OP_SLR: begin
        if (sh_big) begin
          alu_res = '0;
          alu_c   = 1'b0;
        end else if (!sh_zero) begin
          alu_res = shr_w[WIDTH:1];
          alu_c   = shr_w[0];
        end
        upd = '{res: 1'b1, zs: 1'b1, c: !sh_zero, of: 1'b1};
      end
      ALU2OP_SAL, ALU2OP_SLL: begin
        if (sh_big) begin
          alu_res = '0;
          alu_c   = 1'b0;
        end else if (!sh_zero) begin
          alu_res = shl_w[WIDTH-1:0];
          alu_c   = shl_w[WIDTH];
        end
        upd = '{res: 1'b1, zs: 1'b1, c: !sh_zero, of: 1'b1};
      end
      ALU2OP_ROL: begin
        if (!rot_zero) alu_res = rol_res;
        alu_c = alu_res[0];
        upd   = '{res: 1'b1, zs: 1'b1, c: !rot_zero, of: 1'b1};
      end
      ALU2OP_ROR: begin
        if (!rot_zero) alu_res = ror_res;
        alu_c = alu_res[WIDTH-1];
        upd   = '{res: 1'b1, zs: 1'b1, c: !rot_zero, of: 1'b1};
      end
      ALU2OP_AND, ALU2OP_OR, ALU2OP_XOR: begin
        if (i_ALUOp == ALU2OP_AND)     alu_res = i_Data1 & i_Data2;
        else if (i_ALUOp == ALU2OP_OR) alu_res = i_Data1 | i_Data2;
        else                           alu_res = i_Data1 ^ i_Data2;
        alu_c  = 1'b0;
        alu_of = 1'b0;
        upd    = '1;
      end
      default: ;  // MUL/DIV go to the iterative unit; 18-31 change nothing
    endcase
    if (is_shift) alu_of = alu_res[WIDTH-1] ^ i_Data1[WIDTH-1];
  end

  seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clk      (i_CLK),
    .rst      (i_RST),
    .start    (md_start),
    .is_div   (i_ALUOp == ALU2OP_DIV),
    .op_a     (i_Data1),
    .op_b     (i_Data2),
    .done     (md_done),
    .div_mode (md_div),
    .res_lo   (md_lo),
    .res_hi   (md_hi)
  );

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state      <= ST_IDLE;
      o_Ready    <= 1'b1;
      o_Valid    <= 1'b0;
      o_Result   <= '0;
      o_ResultHi <= '0;
      o_Z        <= 1'b0;
      o_S        <= 1'b0;
      o_C        <= 1'b0;
      o_OF       <= 1'b0;
      o_DivZero  <= 1'b0;
    end else begin
      o_Valid   <= 1'b0;
      o_DivZero <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (md_start) begin
            state   <= ST_BUSY;
            o_Ready <= 1'b0;
          end else if (i_Valid) begin
            o_Valid <= 1'b1;
            if (div_zero) begin
              // Divide by zero finishes immediately with a saturated quotient.
              o_Result   <= '1;
              o_ResultHi <= i_Data1;
              o_DivZero  <= 1'b1;
              o_Z        <= 1'b0;
              o_S        <= 1'b1;
              o_C        <= 1'b0;
              o_OF       <= 1'b1;
            end else begin
              if (upd.res) begin
                o_Result   <= alu_res;
                o_ResultHi <= '0;
              end
              if (upd.zs) begin
                o_Z <= (alu_res == '0);
                o_S <= alu_res[WIDTH-1];
              end
              if (upd.c)  o_C  <= alu_c;
              if (upd.of) o_OF <= alu_of;
            end
          end
        end
        ST_BUSY: begin
          if (md_done) begin
            state      <= ST_IDLE;
            o_Ready    <= 1'b1;
            o_Valid    <= 1'b1;
            o_Result   <= md_lo;
            o_ResultHi <= md_hi;
            // MUL flags describe the full double-width product.
            o_Z  <= md_div ? (md_lo == '0) : ({md_hi, md_lo} == '0);
            o_S  <= md_div ? md_lo[WIDTH-1] : md_hi[WIDTH-1];
            o_C  <= !md_div && (md_hi != '0);
            o_OF <= !md_div && (md_hi != '0);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_alu.sv
// -----------------------------------------------------------------------------
// tb_seq_alu
// Drives a WIDTH=8 and a WIDTH=16 seq_alu with directed vectors. Each issue
// pushes its hand-computed response into that instance's queue; a monitor per
// instance pops and compares whenever o_Valid is seen.
// -----------------------------------------------------------------------------
module tb_seq_alu;
  import seq_alu_pkg::*;

  typedef struct {
    string       name;
    logic [15:0] res;
    logic [15:0] hi;
    logic [3:0]  zsco;  // {Z,S,C,OF}
    logic        dz;
    int          lat;   // clock edges from the accepting edge to the result edge
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, v8, v16;
  logic [4:0]  op;
  logic [7:0]  a8, b8, r8, h8;
  logic [15:0] a16, b16, r16, h16;
  logic rdy8, ov8, z8, s8, c8, of8, dz8;
  logic rdy16, ov16, z16, s16, c16, of16, dz16;

  seq_alu #(.WIDTH(8)) dut8 (
    .i_CLK(clk), .i_RST(rst), .i_Valid(v8), .o_Ready(rdy8), .i_ALUOp(op),
    .i_Data1(a8), .i_Data2(b8), .o_Valid(ov8), .o_Result(r8), .o_ResultHi(h8),
    .o_Z(z8), .o_S(s8), .o_C(c8), .o_OF(of8), .o_DivZero(dz8)
  );

  seq_alu #(.WIDTH(16)) dut16 (
    .i_CLK(clk), .i_RST(rst), .i_Valid(v16), .o_Ready(rdy16), .i_ALUOp(op),
    .i_Data1(a16), .i_Data2(b16), .o_Valid(ov16), .o_Result(r16), .o_ResultHi(h16),
    .o_Z(z16), .o_S(s16), .o_C(c16), .o_OF(of16), .o_DivZero(dz16)
  );

  exp_t q8[$], q16[$];
  exp_t e8, e16;
  int   n_tests = 0, n_fail = 0;
  int   cyc = 0, nval8 = 0, nval16 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic exp_t mk(input string n, input logic [15:0] res, input logic [15:0] hi,
                              input logic [3:0] zsco, input logic dz, input int lat);
    exp_t e;
    e.name = n; e.res = res; e.hi = hi; e.zsco = zsco; e.dz = dz; e.lat = lat; e.acc = 0;
    return e;
  endfunction

  // Compared vector layout: {result, result_hi, Z,S,C,OF, divzero, latency}.
  always @(negedge clk) begin
    if (ov8 === 1'b1) begin
      nval8++;
      if (q8.size() == 0) check("w8 unexpected o_Valid", 1, 0);
      else begin
        e8 = q8.pop_front();
        check(e8.name, {16'(r8), 16'(h8), z8, s8, c8, of8, dz8, 16'(cyc - e8.acc)},
                       {e8.res, e8.hi, e8.zsco, e8.dz, 16'(e8.lat)});
      end
    end
  end

  always @(negedge clk) begin
    if (ov16 === 1'b1) begin
      nval16++;
      if (q16.size() == 0) check("w16 unexpected o_Valid", 1, 0);
      else begin
        e16 = q16.pop_front();
        check(e16.name, {r16, h16, z16, s16, c16, of16, dz16, 16'(cyc - e16.acc)},
                        {e16.res, e16.hi, e16.zsco, e16.dz, 16'(e16.lat)});
      end
    end
  end

  function automatic logic ready_of(input int w);
    return (w == 8) ? rdy8 : rdy16;
  endfunction

  // Waits for ready, holds the request across one edge, then logs the
  // expectation with the accepting edge's cycle number.
  task automatic issue(input int w, input logic [4:0] opc, input logic [15:0] d1,
                       input logic [15:0] d2, input bit push, input exp_t e);
    int budget = 0;
    while (ready_of(w) !== 1'b1 && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (budget >= 200) check("ready timeout", 0, 1);
    op = opc;
    if (w == 8) begin a8 = d1[7:0]; b8 = d2[7:0]; v8 = 1'b1; end
    else        begin a16 = d1;     b16 = d2;     v16 = 1'b1; end
    @(posedge clk); #1;
    v8 = 1'b0; v16 = 1'b0;
    e.acc = cyc;
    if (push) begin
      if (w == 8) q8.push_back(e);
      else        q16.push_back(e);
    end
  endtask

  task automatic count_busy(input int w, input int exp_n);
    int n = 0;
    while (ready_of(w) !== 1'b1 && n < 1000) begin
      n++;
      @(posedge clk); #1;
    end
    check($sformatf("w%0d busy cycles", w), n, exp_n);
  endtask

  task automatic check_idle(input int w, input string name);
    logic [63:0] act;
    if (w == 8) act = {16'(r8), 16'(h8), z8, s8, c8, of8, dz8, ov8, rdy8};
    else        act = {r16, h16, z16, s16, c16, of16, dz16, ov16, rdy16};
    check(name, act, 64'h1);
  endtask

  // Abort a MUL in its 4th busy cycle, then confirm reset state and silence.
  task automatic reset_abort(input int w);
    int nv;
    issue(w, ALU2OP_MUL, 16'h3, 16'h5, 1'b0, mk("", 0, 0, 0, 0, 0));
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle(w, $sformatf("w%0d reset during busy", w));
    nv = (w == 8) ? nval8 : nval16;
    repeat (w + 4) begin @(posedge clk); #1; end
    check($sformatf("w%0d no o_Valid after abort", w), (w == 8) ? nval8 : nval16, nv);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; v8 = 1'b0; v16 = 1'b0; op = '0;
    a8 = '0; b8 = '0; a16 = '0; b16 = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle(8, "w8 reset state");
    check_idle(16, "w16 reset state");

    // ---------------- WIDTH = 8 ----------------
    issue(8, ALU2OP_ADD, 16'h7F, 16'h01, 1, mk("w8 ADD 7F+01", 16'h80, 0, 4'b0101, 0, 0));
    issue(8, ALU2OP_ADD, 16'hFF, 16'h01, 1, mk("w8 ADD FF+01", 16'h00, 0, 4'b1010, 0, 0));
    issue(8, ALU2OP_ADC, 16'h10, 16'h00, 1, mk("w8 ADC 10+00+C", 16'h11, 0, 4'b0000, 0, 0));
    issue(8, ALU2OP_SUB, 16'h00, 16'h01, 1, mk("w8 SUB 00-01", 16'hFF, 0, 4'b0110, 0, 0));
    issue(8, ALU2OP_SLR, 16'h81, 16'h08, 1, mk("w8 SLR 81>>8", 16'h00, 0, 4'b1001, 0, 0));
    issue(8, ALU2OP_ROR, 16'h01, 16'h09, 1, mk("w8 ROR 01 by 9", 16'h80, 0, 4'b0111, 0, 0));
    issue(8, ALU2OP_SAR, 16'h80, 16'h09, 1, mk("w8 SAR 80 by 9", 16'hFF, 0, 4'b0110, 0, 0));
    issue(8, ALU2OP_SLL, 16'h81, 16'h01, 1, mk("w8 SLL 81 by 1", 16'h02, 0, 4'b0011, 0, 0));
    issue(8, ALU2OP_SBB, 16'h10, 16'h01, 1, mk("w8 SBB 10-01-C", 16'h0E, 0, 4'b0000, 0, 0));
    issue(8, ALU2OP_ROL, 16'h80, 16'h01, 1, mk("w8 ROL 80 by 1", 16'h01, 0, 4'b0011, 0, 0));
    issue(8, ALU2OP_SLR, 16'h81, 16'h00, 1, mk("w8 SLR by 0", 16'h81, 0, 4'b0110, 0, 0));
    issue(8, ALU2OP_XOR, 16'hFF, 16'hFF, 1, mk("w8 XOR FF^FF", 16'h00, 0, 4'b1000, 0, 0));
    issue(8, ALU2OP_NOT, 16'h0F, 16'h00, 1, mk("w8 NOT 0F", 16'hF0, 0, 4'b1000, 0, 0));
    issue(8, ALU2OP_MUL, 16'hFF, 16'hFF, 1, mk("w8 MUL FFxFF", 16'h01, 16'hFE, 4'b0111, 0, 8));
    count_busy(8, 8);
    issue(8, ALU2OP_DIV, 16'hC8, 16'h07, 1, mk("w8 DIV 200/7", 16'h1C, 16'h04, 4'b0000, 0, 8));
    issue(8, ALU2OP_DIV, 16'h05, 16'h00, 1, mk("w8 DIV 05/00", 16'hFF, 16'h05, 4'b0101, 1, 0));
    issue(8, ALU2OP_PD2, 16'h33, 16'h5A, 1, mk("w8 PD2 5A", 16'h5A, 0, 4'b0101, 0, 0));
    issue(8, 5'd20,      16'h12, 16'h34, 1, mk("w8 no-op 20", 16'h5A, 0, 4'b0101, 0, 0));
    reset_abort(8);
    issue(8, ALU2OP_ADD, 16'h01, 16'h01, 1, mk("w8 ADD after abort", 16'h02, 0, 4'b0000, 0, 0));

    // ---------------- WIDTH = 16 ----------------
    issue(16, ALU2OP_ADD, 16'h7FFF, 16'h0001, 1, mk("w16 ADD 7FFF+1", 16'h8000, 0, 4'b0101, 0, 0));
    issue(16, ALU2OP_ADD, 16'hFFFF, 16'h0001, 1, mk("w16 ADD FFFF+1", 16'h0000, 0, 4'b1010, 0, 0));
    issue(16, ALU2OP_ADC, 16'h0010, 16'h0000, 1, mk("w16 ADC 10+0+C", 16'h0011, 0, 4'b0000, 0, 0));
    issue(16, ALU2OP_SUB, 16'h0000, 16'h0001, 1, mk("w16 SUB 0-1", 16'hFFFF, 0, 4'b0110, 0, 0));
    issue(16, ALU2OP_SLR, 16'h8001, 16'h0010, 1, mk("w16 SLR by 16", 16'h0000, 0, 4'b1001, 0, 0));
    issue(16, ALU2OP_ROR, 16'h0001, 16'h0011, 1, mk("w16 ROR by 17", 16'h8000, 0, 4'b0111, 0, 0));
    issue(16, ALU2OP_SAR, 16'h8000, 16'h0010, 1, mk("w16 SAR by 16", 16'hFFFF, 0, 4'b0110, 0, 0));
    issue(16, ALU2OP_SLL, 16'h8001, 16'h000F, 1, mk("w16 SLL by 15", 16'h8000, 0, 4'b0100, 0, 0));
    issue(16, ALU2OP_MUL, 16'h0000, 16'h1234, 1, mk("w16 MUL 0x1234", 16'h0000, 16'h0000, 4'b1000, 0, 16));
    issue(16, ALU2OP_MUL, 16'hFFFF, 16'hFFFF, 1, mk("w16 MUL FFFFxFFFF", 16'h0001, 16'hFFFE, 4'b0111, 0, 16));
    count_busy(16, 16);
    issue(16, ALU2OP_DIV, 16'h03E8, 16'h0007, 1, mk("w16 DIV 1000/7", 16'h008E, 16'h0006, 4'b0000, 0, 16));
    issue(16, ALU2OP_DIV, 16'h0005, 16'h0000, 1, mk("w16 DIV 5/0", 16'hFFFF, 16'h0005, 4'b0101, 1, 0));
    reset_abort(16);
    issue(16, ALU2OP_ADD, 16'h0001, 16'h0001, 1, mk("w16 ADD after abort", 16'h0002, 0, 4'b0000, 0, 0));

    repeat (5) begin @(posedge clk); #1; end
    check("w8 scoreboard drained", q8.size(), 0);
    check("w16 scoreboard drained", q16.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/seq_alu.md
# seq_alu

Parametrised multi-cycle successor to the 8-bit CPU ALU. It adds a WIDTH parameter, a valid/ready handshake, true carry/borrow chaining (ADC/SBB), and iterative unsigned MUL/DIV with a double-width result. It sits between the register-file read stage and the write-back stage. The control FSM stalls issue while o_Ready is low.

## Interface
- WIDTH, 8: operand/result width; any integer ≥ 4. Shift amount uses the low clog2(WIDTH) bits of i_Data2 plus a range check.
- i_CLK  in  1  clock; all state updates on posedge.
- i_RST  in  1  synchronous reset, active-high; sampled on posedge i_CLK.
- i_Valid  in  1  request strobe; accepted on an edge where i_Valid && o_Ready.
- o_Ready  out  1  block can accept a request this cycle.
- i_ALUOp  in  5  operation code (ALU2OP_*).
- i_Data1, i_Data2  in  WIDTH  operands.
- o_Valid  out  1  one-cycle pulse; result/flags updated this cycle.
- o_Result  out  WIDTH  primary result (MUL low half, DIV quotient).
- o_ResultHi  out  WIDTH  MUL high half / DIV remainder; 0 for other ops.
- o_Z, o_S, o_C, o_OF  out  1 each  flag register.
- o_DivZero  out  1  set with o_Valid when DIV had i_Data2 == 0, else 0.

## Operation
- Reset: o_Result=0, o_ResultHi=0, all flags 0, o_Valid=0, o_DivZero=0, o_Ready=1, FSM→IDLE.
- FSM states:
  - IDLE (o_Ready=1). Accepting a single-cycle op → stays IDLE. Accepting MUL/DIV → BUSY.
  - BUSY (o_Ready=0, counter WIDTH-1..0). Counter reaching 0 → IDLE.
- Codes and result rules:
  - 0 PD1, 1 PD2: pass the operand; flags unchanged.
  - 2 ADD, 3 SUB: {C,Result}=D1±D2; C is borrow for SUB.
  - 4 ADC: D1+D2+C. 5 SBB: D1−D2−C.
  - 6 SAR, 7 SLR, 8 SAL, 9 SLL: shifts by amt=D2.
    - amt 0: Result=D1, C unchanged.
    - 1 ≤ amt < WIDTH: C = last bit shifted out.
    - amt ≥ WIDTH: Result=0, or all sign bits for SAR; C=0 for logical shifts, MSB of D1 for SAR.
  - 10 ROL, 11 ROR: amt = D2 mod WIDTH. amt 0: Result=D1, C unchanged. Otherwise C = bit rotated across the boundary (new LSB for ROL, new MSB for ROR).
  - 12 AND, 13 OR, 14 XOR: C=OF=0.
  - 15 NOT: Result=~D1; flags unchanged.
  - 16 MUL: unsigned shift-add; {Hi,Result}=D1*D2; C=OF=(Hi≠0); Z over full 2·WIDTH product; S=Hi MSB.
  - 17 DIV: unsigned restoring; Result=quotient, Hi=remainder; C=OF=0.
  - 18–31: no-op; outputs and flags unchanged, o_Valid still pulses.
- Flag rules:
  - Wherever flags update: Z=(Result==0) except MUL; S=Result MSB.
  - ADD/ADC: OF = operands share a sign and the result sign differs.
  - SUB/SBB: OF = operand signs differ and the result sign differs from D1.
  - Shifts/rotates: OF = Result MSB ≠ D1 MSB.
- DIV by zero: completes in 1 cycle without entering BUSY. Result=all ones, Hi=D1, o_DivZero=1, Z=0, S=1, C=0, OF=1.
- Operands and op are captured at acceptance; inputs may change while BUSY.

## Timing
- Single-cycle ops: accepted at edge E0; results, flags and o_Valid visible after E0. Back-to-back issue every cycle.
- MUL/DIV: accepted at E0; o_Ready=0 after E0.
  - Iterations run on edges E1..E(WIDTH).
  - Results and o_Valid appear after E(WIDTH); latency = WIDTH cycles.
  - o_Ready=1 in the o_Valid cycle, so the next request can be accepted in the same cycle.
- o_Result/flags hold between o_Valid pulses. There is no output backpressure; the consumer must take data on o_Valid.
- ADC/SBB issued immediately after a producing op use the C updated by that op.
- i_RST during BUSY: abort, no o_Valid, all outputs reset values after the edge.
- i_RST wins over a simultaneous i_Valid.

## Structure
- ALU2OP_* 5-bit codes (0–17 above) are added to the shared constants include, alongside the existing ALUOP_* codes. Existing codes are not modified.
- Sub-module seq_alu_muldiv holds the WIDTH-step shift-add/restoring-divide datapath, the step counter, and a done strobe. The top level keeps the FSM, single-cycle datapath and flag register.

## Test plan
- ADD 0x7F+0x01 → Result 0x80, S=1, OF=1, C=0, Z=0, o_Valid one cycle after accept.
- ADD 0xFF+0x01 then ADC 0x10+0x00 back-to-back → 0x00 (Z=1, C=1), then 0x11 (C=0).
- SUB 0x00−0x01 → 0xFF, C=1, S=1, OF=0. SLR 0x81 by 8 → 0x00, C=0, Z=1. ROR 0x01 by 9 → 0x80, C=1.
- MUL 0xFF×0xFF → Hi 0xFE, Result 0x01, C=OF=1. o_Ready low for exactly 8 cycles; o_Valid 8 cycles after accept.
- DIV 200/7 → Result 0x1C, Hi 0x04, o_DivZero=0. DIV 0x05/0x00 → 0xFF, Hi 0x05, o_DivZero=1, latency 1.
- Assert i_RST on the 4th BUSY cycle of a MUL → no o_Valid; all outputs 0 and o_Ready=1 after the edge. Repeat the suite with WIDTH=16.
